// File: rtl/recorder_pkg.sv
// Shared types and constants for the event recorder: severity levels,
// default-width record layout and drop-counter width.
package recorder_pkg;

    localparam int unsigned DROP_COUNT_WIDTH = 16;
    localparam int unsigned LEVEL_WIDTH      = 3;

    typedef enum logic [LEVEL_WIDTH-1:0] {
        LVL_TRACE = 3'd0,
        LVL_DEBUG = 3'd1,
        LVL_INFO  = 3'd2,
        LVL_WARN  = 3'd3,
        LVL_ERROR = 3'd4,
        LVL_FATAL = 3'd5
    } level_e;

    // Record layout at the default widths (topic 4, payload 16, timestamp 32)
    typedef struct packed {
        level_e       level;
        logic [3:0]   topic;
        logic [15:0]  payload;
        logic [31:0]  timestamp;
    } record_t;

    // Undefined encodings above FATAL are treated as INFO
    function automatic logic [LEVEL_WIDTH-1:0] coerce_level(input logic [LEVEL_WIDTH-1:0] lvl);
        return (lvl > LVL_FATAL) ? LVL_INFO : lvl;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with a registered head word and registered
// full/empty flags; the caller guarantees no push when full without a pop.
module event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_full;
    logic [WIDTH-1:0] r_data;

    logic [PTR_W-1:0] w_wptr_next;
    logic [PTR_W-1:0] w_rptr_next;
    logic [CNT_W-1:0] w_count_next;
    logic [WIDTH-1:0] w_head_next;

    // Next head is the word being written now when nothing older remains
    always_comb begin
        w_wptr_next  = i_push ? r_wptr + PTR_W'(1) : r_wptr;
        w_rptr_next  = i_pop  ? r_rptr + PTR_W'(1) : r_rptr;
        w_count_next = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        w_head_next  = (i_push && (r_wptr == w_rptr_next)) ? i_data : r_mem[w_rptr_next];
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_wptr  <= w_wptr_next;
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            if (w_count_next != '0) begin
                r_data <= w_head_next;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_full  = r_full;
    assign o_empty = ~r_valid;

endmodule

// File: rtl/event_recorder.sv
// Timestamps, level-coerces and buffers events; counts events lost to a full FIFO.
// Define EVENT_RECORDER_FILTER_EN to add a min_level input that discards low-severity events.
module event_recorder
    import recorder_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned TOPIC_WIDTH   = 4,
    parameter int unsigned PAYLOAD_WIDTH = 16,
    parameter int unsigned TS_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        evt_valid,
    input  logic [LEVEL_WIDTH-1:0]      evt_level,
    input  logic [TOPIC_WIDTH-1:0]      evt_topic,
    input  logic [PAYLOAD_WIDTH-1:0]    evt_payload,
`ifdef EVENT_RECORDER_FILTER_EN
    input  logic [LEVEL_WIDTH-1:0]      min_level,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LEVEL_WIDTH-1:0]      out_level,
    output logic [TOPIC_WIDTH-1:0]      out_topic,
    output logic [PAYLOAD_WIDTH-1:0]    out_payload,
    output logic [TS_WIDTH-1:0]         out_timestamp,
    output logic [DROP_COUNT_WIDTH-1:0] dropped_count,
    output logic                        overflow
);

    typedef struct packed {
        logic [LEVEL_WIDTH-1:0]   level;
        logic [TOPIC_WIDTH-1:0]   topic;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [TS_WIDTH-1:0]      timestamp;
    } rec_t;

    localparam int unsigned REC_W = $bits(rec_t);

    logic [TS_WIDTH-1:0]         r_ts;
    logic [DROP_COUNT_WIDTH-1:0] r_drop_cnt;
    logic                        r_overflow;

    rec_t w_in;
    rec_t w_head;
    logic w_pass;
    logic w_req;
    logic w_pop;
    logic w_accept;
    logic w_drop;
    logic w_full;
    logic w_empty;
    logic w_valid;

    always_comb begin
        w_in.level     = coerce_level(evt_level);
        w_in.topic     = evt_topic;
        w_in.payload   = evt_payload;
        w_in.timestamp = r_ts;
    end

`ifdef EVENT_RECORDER_FILTER_EN
    assign w_pass = (w_in.level >= min_level);
`else
    assign w_pass = 1'b1;
`endif

    // A full FIFO still accepts when its head leaves in the same cycle
    assign w_req    = evt_valid && w_pass;
    assign w_pop    = out_ready && !w_empty;
    assign w_accept = w_req && (!w_full || w_pop);
    assign w_drop   = w_req && !w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_COUNT_WIDTH'(1);
                end
            end
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_valid (w_valid),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid     = w_valid;
    assign out_level     = w_head.level;
    assign out_topic     = w_head.topic;
    assign out_payload   = w_head.payload;
    assign out_timestamp = w_head.timestamp;
    assign dropped_count = r_drop_cnt;
    assign overflow      = r_overflow;

endmodule
